// File: rtl/multicycle_core.sv
// rtl/multicycle_core.sv - multicycle MIPS-subset core with unified memory handshake
module multicycle_core #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          NUM_HEX  = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   output logic [31:0]            adr,
   output logic                   memread,
   output logic                   memwrite,
   output logic [31:0]            writedata,
   input  logic [31:0]            readdata,
   input  logic                   mem_ready,
   output logic [31:0]            pc,
   output logic                   instr_done,
   output logic                   illegal,
   output logic [7*NUM_HEX-1:0]   hex
);

   typedef enum logic [3:0] {
      S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
      S_EXEC, S_ALUWB, S_ADDIEX, S_ADDIWB, S_BRANCH, S_JUMP
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_SLT = 3'b111;

   state_t                  state_q, state_d;
   logic [31:0]             pc_q, pc_d;
   logic [31:0]             ir_q, ir_d;
   logic [31:0]             a_q, a_d;
   logic [31:0]             b_q, b_d;
   logic [31:0]             aluout_q, aluout_d;
   logic [31:0]             data_q, data_d;
   logic [4*NUM_HEX-1:0]    display_q, display_d;
   logic                    illegal_q, illegal_d;

   logic [31:0]             rf_q [0:31];
   logic                    rf_we;
   logic [4:0]              rf_wa;
   logic [31:0]             rf_wd;
   logic [31:0]             rf_a, rf_b;

   logic [5:0]              op;
   logic [4:0]              rs, rt, rd;
   logic [5:0]              funct;
   logic [31:0]             signimm;
   logic [2:0]              alu_ctl;
   logic                    funct_ok;

   assign op      = ir_q[31:26];
   assign rs      = ir_q[25:21];
   assign rt      = ir_q[20:16];
   assign rd      = ir_q[15:11];
   assign funct   = ir_q[5:0];
   assign signimm = {{16{ir_q[15]}}, ir_q[15:0]};

   // $0 is hardwired to zero regardless of what the array holds
   assign rf_a = (rs == 5'd0) ? 32'd0 : rf_q[rs];
   assign rf_b = (rt == 5'd0) ? 32'd0 : rf_q[rt];

   assign pc        = pc_q;
   assign writedata = b_q;
   assign illegal   = illegal_q;

   function automatic logic [31:0] alu_op(input logic [2:0] ctl, input logic [31:0] x,
                                          input logic [31:0] y);
      case (ctl)
         ALU_AND: alu_op = x & y;
         ALU_OR:  alu_op = x | y;
         ALU_ADD: alu_op = x + y;
         ALU_SUB: alu_op = x - y;
         ALU_SLT: alu_op = {31'd0, $signed(x) < $signed(y)};
         default: alu_op = 32'd0;
      endcase
   endfunction

   // segment order is {g,f,e,d,c,b,a}, active high
   function automatic logic [6:0] seg7(input logic [3:0] nib);
      case (nib)
         4'h0: seg7 = 7'h3F;
         4'h1: seg7 = 7'h06;
         4'h2: seg7 = 7'h5B;
         4'h3: seg7 = 7'h4F;
         4'h4: seg7 = 7'h66;
         4'h5: seg7 = 7'h6D;
         4'h6: seg7 = 7'h7D;
         4'h7: seg7 = 7'h07;
         4'h8: seg7 = 7'h7F;
         4'h9: seg7 = 7'h6F;
         4'hA: seg7 = 7'h77;
         4'hB: seg7 = 7'h7C;
         4'hC: seg7 = 7'h39;
         4'hD: seg7 = 7'h5E;
         4'hE: seg7 = 7'h79;
         default: seg7 = 7'h71;
      endcase
   endfunction

   // R-type funct to ALU control; unknown functs are flagged illegal in DECODE
   always_comb begin
      alu_ctl  = ALU_ADD;
      funct_ok = 1'b1;
      case (funct)
         6'b100000: alu_ctl = ALU_ADD;
         6'b100010: alu_ctl = ALU_SUB;
         6'b100100: alu_ctl = ALU_AND;
         6'b100101: alu_ctl = ALU_OR;
         6'b101010: alu_ctl = ALU_SLT;
         default:   funct_ok = 1'b0;
      endcase
   end

   // control FSM next-state, datapath next values and memory-side outputs
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      ir_d       = ir_q;
      a_d        = a_q;
      b_d        = b_q;
      aluout_d   = aluout_q;
      data_d     = data_q;
      display_d  = display_q;
      illegal_d  = illegal_q;
      rf_we      = 1'b0;
      rf_wa      = rt;
      rf_wd      = data_q;
      adr        = pc_q;
      memread    = 1'b0;
      memwrite   = 1'b0;
      instr_done = 1'b0;

      case (state_q)
         S_FETCH: begin
            memread = 1'b1;
            if (mem_ready) begin
               ir_d    = readdata;
               pc_d    = pc_q + 32'd4;
               state_d = S_DECODE;
            end
         end
         S_DECODE: begin
            a_d      = rf_a;
            b_d      = rf_b;
            aluout_d = pc_q + (signimm << 2);
            case (op)
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_BEQ:       state_d = S_BRANCH;
               OP_ADDI:      state_d = S_ADDIEX;
               OP_J:         state_d = S_JUMP;
               OP_RTYPE: begin
                  if (funct_ok) begin
                     state_d = S_EXEC;
                  end else begin
                     illegal_d  = 1'b1;
                     instr_done = 1'b1;
                     state_d    = S_FETCH;
                  end
               end
               default: begin
                  illegal_d  = 1'b1;
                  instr_done = 1'b1;
                  state_d    = S_FETCH;
               end
            endcase
         end
         S_MEMADR: begin
            aluout_d = a_q + signimm;
            state_d  = (op == OP_LW) ? S_MEMRD : S_MEMWR;
         end
         S_MEMRD: begin
            adr     = aluout_q;
            memread = 1'b1;
            if (mem_ready) begin
               data_d  = readdata;
               state_d = S_MEMWB;
            end
         end
         S_MEMWB: begin
            rf_we      = 1'b1;
            rf_wa      = rt;
            rf_wd      = data_q;
            instr_done = 1'b1;
            state_d    = S_FETCH;
         end
         S_MEMWR: begin
            adr      = aluout_q;
            memwrite = 1'b1;
            if (mem_ready) begin
               instr_done = 1'b1;
               state_d    = S_FETCH;
            end
         end
         S_EXEC: begin
            aluout_d = alu_op(alu_ctl, a_q, b_q);
            state_d  = S_ALUWB;
         end
         S_ALUWB: begin
            rf_we      = 1'b1;
            rf_wa      = rd;
            rf_wd      = aluout_q;
            instr_done = 1'b1;
            state_d    = S_FETCH;
         end
         S_ADDIEX: begin
            aluout_d = a_q + signimm;
            state_d  = S_ADDIWB;
         end
         S_ADDIWB: begin
            rf_we      = 1'b1;
            rf_wa      = rt;
            rf_wd      = aluout_q;
            instr_done = 1'b1;
            state_d    = S_FETCH;
         end
         S_BRANCH: begin
            if (alu_op(ALU_SUB, a_q, b_q) == 32'd0) begin
               pc_d = aluout_q;
            end
            instr_done = 1'b1;
            state_d    = S_FETCH;
         end
         S_JUMP: begin
            pc_d       = {pc_q[31:28], ir_q[25:0], 2'b00};
            instr_done = 1'b1;
            state_d    = S_FETCH;
         end
         default: state_d = S_FETCH;
      endcase

      // a reset cycle must never write memory, the register file or the display
      if (reset) begin
         memread    = 1'b0;
         memwrite   = 1'b0;
         instr_done = 1'b0;
         rf_we      = 1'b0;
      end

      // display follows every register write, including ones aimed at $0
      if (rf_we) begin
         display_d = rf_wd[4*NUM_HEX-1:0];
      end
   end

   // FSM state and datapath registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_FETCH;
         pc_q      <= RESET_PC;
         ir_q      <= 32'd0;
         a_q       <= 32'd0;
         b_q       <= 32'd0;
         aluout_q  <= 32'd0;
         data_q    <= 32'd0;
         display_q <= '0;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         ir_q      <= ir_d;
         a_q       <= a_d;
         b_q       <= b_d;
         aluout_q  <= aluout_d;
         data_q    <= data_d;
         display_q <= display_d;
         illegal_q <= illegal_d;
      end
   end

   // register file write port; contents survive reset
   always_ff @(posedge clk) begin
      if (rf_we && (rf_wa != 5'd0)) begin
         rf_q[rf_wa] <= rf_wd;
      end
   end

   for (genvar i = 0; i < NUM_HEX; i++) begin : g_hex
      assign hex[7*i +: 7] = seg7(display_q[4*i +: 4]);
   end

endmodule

// File: tb/tb_multicycle_core.sv
// tb/tb_multicycle_core.sv - directed bench for multicycle_core
module tb_multicycle_core;

   logic        clk = 1'b0;
   logic        reset;
   logic        mem_ready;
   logic [31:0] adr, writedata, readdata, pc;
   logic        memread, memwrite, instr_done, illegal;
   logic [55:0] hex;

   multicycle_core #(.RESET_PC(32'h0000_0000), .NUM_HEX(8)) dut (
      .clk(clk), .reset(reset), .adr(adr), .memread(memread), .memwrite(memwrite),
      .writedata(writedata), .readdata(readdata), .mem_ready(mem_ready), .pc(pc),
      .instr_done(instr_done), .illegal(illegal), .hex(hex)
   );

   always #5 clk = ~clk;

   // instruction space below 0x200, data space from 0x200
   logic [31:0] imem [0:255];
   logic [31:0] dmem [0:15];
   int          wr_cnt = 0;
   int          both_cnt = 0;

   always_comb readdata = (adr >= 32'h200) ? dmem[adr[5:2]] : imem[adr[9:2]];

   always @(posedge clk) begin
      if (memwrite && mem_ready) begin
         dmem[adr[5:2]] <= writedata;
         wr_cnt         <= wr_cnt + 1;
      end
      if (memread && memwrite) both_cnt <= both_cnt + 1;
   end

   localparam logic [6:0] SEG [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                       7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [55:0] exp_hex(input logic [31:0] v);
      logic [55:0] r;
      for (int i = 0; i < 8; i++) r[7*i +: 7] = SEG[v[4*i +: 4]];
      return r;
   endfunction

   function automatic logic [31:0] f_addi(input logic [4:0] rt, input logic [4:0] rs,
                                          input logic [15:0] imm);
      return {6'b001000, rs, rt, imm};
   endfunction
   function automatic logic [31:0] f_r(input logic [4:0] rd, input logic [4:0] rs,
                                       input logic [4:0] rt, input logic [5:0] fn);
      return {6'b000000, rs, rt, rd, 5'd0, fn};
   endfunction
   function automatic logic [31:0] f_beq(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [15:0] off);
      return {6'b000100, rs, rt, off};
   endfunction
   function automatic logic [31:0] f_lw(input logic [4:0] rt, input logic [4:0] rs,
                                        input logic [15:0] off);
      return {6'b100011, rs, rt, off};
   endfunction
   function automatic logic [31:0] f_sw(input logic [4:0] rt, input logic [4:0] rs,
                                        input logic [15:0] off);
      return {6'b101011, rs, rt, off};
   endfunction

   // runs one instruction from its FETCH cycle; stalls withhold mem_ready per phase
   task automatic run_instr(input int fstall, input int dstall, output int cycles,
                            output int wcycles, output logic [31:0] wadr,
                            output logic [31:0] wdata);
      int  fs = fstall;
      int  ds = dstall;
      logic done = 1'b0;
      cycles  = 0;
      wcycles = 0;
      wadr    = 32'd0;
      wdata   = 32'd0;
      while (!done && cycles < 40) begin
         @(negedge clk);
         cycles++;
         if (memread && adr < 32'h200) begin
            if (fs > 0) begin mem_ready = 1'b0; fs--; end else mem_ready = 1'b1;
         end else if ((memread || memwrite) && adr >= 32'h200) begin
            if (ds > 0) begin mem_ready = 1'b0; ds--; end else mem_ready = 1'b1;
         end else begin
            mem_ready = 1'b1;
         end
         #1;
         if (memwrite) begin
            wcycles++;
            wadr  = adr;
            wdata = writedata;
         end
         done = instr_done;
      end
      if (!done) begin
         n_checks++;
         n_fail++;
         $display("FAIL instr_done_timeout: got no instr_done within %0d cycles", cycles);
      end
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic [31:0] addr;
      logic [31:0] instr;
      int          cycles;
      logic [31:0] exp_pc;
      logic [31:0] exp_disp;
      logic        exp_ill;
   } vec_t;

   vec_t tbl[$];

   initial begin
      int          cyc, wcyc;
      logic [31:0] wadr, wdata;
      bit          found;

      for (int i = 0; i < 256; i++) imem[i] = 32'd0;

      tbl.push_back('{32'h000, f_addi(5'd2, 5'd0, 16'd5),        4, 32'h004, 32'h0000_0005, 1'b0});
      tbl.push_back('{32'h004, f_addi(5'd3, 5'd0, 16'hFFFF),     4, 32'h008, 32'hFFFF_FFFF, 1'b0});
      tbl.push_back('{32'h008, f_r(5'd4, 5'd3, 5'd3, 6'h20),     4, 32'h00C, 32'hFFFF_FFFE, 1'b0});
      tbl.push_back('{32'h00C, f_r(5'd5, 5'd4, 5'd0, 6'h2A),     4, 32'h010, 32'h0000_0001, 1'b0});
      tbl.push_back('{32'h010, f_beq(5'd2, 5'd2, 16'd2),         3, 32'h01C, 32'h0000_0001, 1'b0});
      tbl.push_back('{32'h01C, f_beq(5'd2, 5'd3, 16'd2),         3, 32'h020, 32'h0000_0001, 1'b0});
      tbl.push_back('{32'h020, {6'b000010, 26'h40},              3, 32'h100, 32'h0000_0001, 1'b0});
      tbl.push_back('{32'h100, 32'hFC00_0000,                    2, 32'h104, 32'h0000_0001, 1'b1});
      tbl.push_back('{32'h104, f_r(5'd7, 5'd2, 5'd3, 6'h22),     4, 32'h108, 32'h0000_0006, 1'b1});
      tbl.push_back('{32'h108, f_r(5'd8, 5'd3, 5'd2, 6'h24),     4, 32'h10C, 32'h0000_0005, 1'b1});
      tbl.push_back('{32'h10C, f_r(5'd9, 5'd2, 5'd4, 6'h25),     4, 32'h110, 32'hFFFF_FFFF, 1'b1});
      tbl.push_back('{32'h110, f_r(5'd10, 5'd3, 5'd2, 6'h2A),    4, 32'h114, 32'h0000_0001, 1'b1});
      tbl.push_back('{32'h114, f_r(5'd10, 5'd2, 5'd3, 6'h2A),    4, 32'h118, 32'h0000_0000, 1'b1});
      tbl.push_back('{32'h118, f_addi(5'd0, 5'd2, 16'd7),        4, 32'h11C, 32'h0000_000C, 1'b1});
      tbl.push_back('{32'h11C, f_r(5'd11, 5'd0, 5'd2, 6'h20),    4, 32'h120, 32'h0000_0005, 1'b1});
      tbl.push_back('{32'h120, f_r(5'd13, 5'd2, 5'd2, 6'h01),    2, 32'h124, 32'h0000_0005, 1'b1});
      tbl.push_back('{32'h124, f_addi(5'd12, 5'd2, 16'hFFFA),    4, 32'h128, 32'hFFFF_FFFF, 1'b1});

      // reset and its visible state
      reset     = 1'b1;
      mem_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_memwrite", {63'd0, memwrite}, 64'd0);
      check("rst_instr_done", {63'd0, instr_done}, 64'd0);
      reset = 1'b0;
      #1;
      check("rst_pc", {32'd0, pc}, 64'h0);
      check("rst_illegal", {63'd0, illegal}, 64'd0);
      check("rst_hex", {8'd0, hex}, {8'd0, exp_hex(32'd0)});
      check("rst_fetch_memread", {63'd0, memread}, 64'd1);
      check("rst_fetch_adr", {32'd0, adr}, 64'h0);

      foreach (tbl[k]) begin
         imem[tbl[k].addr[9:2]] = tbl[k].instr;
         check($sformatf("v%0d_pc_start", k), {32'd0, pc}, {32'd0, tbl[k].addr});
         run_instr(0, 0, cyc, wcyc, wadr, wdata);
         check($sformatf("v%0d_cycles", k), 64'(cyc), 64'(tbl[k].cycles));
         check($sformatf("v%0d_pc", k), {32'd0, pc}, {32'd0, tbl[k].exp_pc});
         check($sformatf("v%0d_hex", k), {8'd0, hex}, {8'd0, exp_hex(tbl[k].exp_disp)});
         check($sformatf("v%0d_illegal", k), {63'd0, illegal}, {63'd0, tbl[k].exp_ill});
      end

      // fetch held off for two cycles
      imem[32'h128 >> 2] = f_addi(5'd13, 5'd0, 16'h0123);
      run_instr(2, 0, cyc, wcyc, wadr, wdata);
      check("fstall_cycles", 64'(cyc), 64'd6);
      check("fstall_pc", {32'd0, pc}, 64'h12C);
      check("fstall_hex", {8'd0, hex}, {8'd0, exp_hex(32'h123)});

      // store: exactly one memwrite cycle, display untouched
      imem[32'h12C >> 2] = f_sw(5'd2, 5'd0, 16'h0200);
      run_instr(0, 0, cyc, wcyc, wadr, wdata);
      check("sw_cycles", 64'(cyc), 64'd4);
      check("sw_memwrite_cycles", 64'(wcyc), 64'd1);
      check("sw_adr", {32'd0, wadr}, 64'h200);
      check("sw_writedata", {32'd0, wdata}, 64'd5);
      check("sw_wr_cnt", 64'(wr_cnt), 64'd1);
      check("sw_mem", {32'd0, dmem[0]}, 64'd5);
      check("sw_hex", {8'd0, hex}, {8'd0, exp_hex(32'h123)});

      // load with three wait cycles in MEMRD
      imem[32'h130 >> 2] = f_lw(5'd6, 5'd0, 16'h0200);
      run_instr(0, 3, cyc, wcyc, wadr, wdata);
      check("lw_cycles", 64'(cyc), 64'd8);
      check("lw_pc", {32'd0, pc}, 64'h134);
      check("lw_hex", {8'd0, hex}, {8'd0, exp_hex(32'd5)});

      imem[32'h134 >> 2] = f_r(5'd14, 5'd6, 5'd6, 6'h20);
      run_instr(0, 0, cyc, wcyc, wadr, wdata);
      check("lw_use_hex", {8'd0, hex}, {8'd0, exp_hex(32'd10)});

      // reset while a store waits on mem_ready
      imem[32'h138 >> 2] = f_sw(5'd14, 5'd0, 16'h0204);
      found = 1'b0;
      for (int c = 0; c < 10 && !found; c++) begin
         @(negedge clk);
         if (memwrite) begin
            found     = 1'b1;
            mem_ready = 1'b0;
         end else begin
            mem_ready = 1'b1;
         end
      end
      check("memwr_reached", {63'd0, found}, 64'd1);
      #1;
      reset = 1'b1;
      #1;
      check("rst_mid_memwrite", {63'd0, memwrite}, 64'd0);
      check("rst_mid_instr_done", {63'd0, instr_done}, 64'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      #1;
      check("post_rst_memwrite", {63'd0, memwrite}, 64'd0);
      check("post_rst_pc", {32'd0, pc}, 64'h0);
      check("post_rst_memread", {63'd0, memread}, 64'd1);
      check("post_rst_adr", {32'd0, adr}, 64'h0);
      check("post_rst_hex", {8'd0, hex}, {8'd0, exp_hex(32'd0)});
      check("post_rst_illegal", {63'd0, illegal}, 64'd0);
      check("post_rst_wr_cnt", 64'(wr_cnt), 64'd1);
      check("rd_wr_exclusive", 64'(both_cnt), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
